// File: rtl/cache_pkg.sv
// Shared width derivations and FSM state type for the line refill buffer.
package cache_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned beats_of(input int unsigned line);
    return line / WORD_W;
  endfunction

  function automatic int unsigned off_w_of(input int unsigned line);
    return $clog2(line / WORD_W);
  endfunction

  function automatic int unsigned idx_w_of(input int unsigned line, input int unsigned size);
    return $clog2(size * 8 / line);
  endfunction

  function automatic int unsigned tag_w_of(input int unsigned line, input int unsigned size);
    return ADDR_W - idx_w_of(line, size) - off_w_of(line);
  endfunction

endpackage

// File: rtl/line_refill_buffer_if.sv
// Request, beat and line handshake bundle between the refill buffer and its neighbours.
interface line_refill_buffer_if #(
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned CACHE_SIZE = 8192
) ();
  import cache_pkg::*;

  localparam int unsigned IDX_W = idx_w_of(CACHE_LINE, CACHE_SIZE);
  localparam int unsigned TAG_W = tag_w_of(CACHE_LINE, CACHE_SIZE);

  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  req_ready;
  logic                  beat_valid;
  logic [31:0]           beat_data;
  logic                  beat_err;
  logic                  crit_valid;
  logic [31:0]           crit_data;
  logic                  line_valid;
  logic                  line_ready;
  logic [CACHE_LINE-1:0] line_data;
  logic [TAG_W-1:0]      line_tag;
  logic [IDX_W-1:0]      line_index;
  logic                  line_err;
  logic                  busy;

  modport master (
    output req_valid, req_addr, beat_valid, beat_data, beat_err, line_ready,
    input  req_ready, crit_valid, crit_data, line_valid, line_data,
           line_tag, line_index, line_err, busy
  );

  modport slave (
    input  req_valid, req_addr, beat_valid, beat_data, beat_err, line_ready,
    output req_ready, crit_valid, crit_data, line_valid, line_data,
           line_tag, line_index, line_err, busy
  );

endinterface

// File: rtl/addr_parser.sv
// Splits a word-granular miss address into {tag, index, offset}.
module addr_parser
  import cache_pkg::*;
#(
  parameter  int unsigned CACHE_LINE = 128,
  parameter  int unsigned CACHE_SIZE = 8192,
  localparam int unsigned OFF_W      = off_w_of(CACHE_LINE),
  localparam int unsigned IDX_W      = idx_w_of(CACHE_LINE, CACHE_SIZE),
  localparam int unsigned TAG_W      = tag_w_of(CACHE_LINE, CACHE_SIZE)
) (
  input  logic [31:0]      i_addr,
  output logic [TAG_W-1:0] o_tag,
  output logic [IDX_W-1:0] o_index,
  output logic [OFF_W-1:0] o_offset
);

  assign o_offset = i_addr[OFF_W-1:0];
  assign o_index  = i_addr[OFF_W +: IDX_W];
  assign o_tag    = i_addr[31 -: TAG_W];

endmodule

// File: rtl/line_refill_buffer.sv
// Critical-word-first cache line refill buffer: assembles BEATS bus words into one line.
module line_refill_buffer
  import cache_pkg::*;
#(
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned CACHE_SIZE = 8192
) (
  input logic                clk,
  input logic                rst,
  line_refill_buffer_if.slave bus
);

  localparam int unsigned BEATS = beats_of(CACHE_LINE);
  localparam int unsigned OFF_W = off_w_of(CACHE_LINE);
  localparam int unsigned IDX_W = idx_w_of(CACHE_LINE, CACHE_SIZE);
  localparam int unsigned TAG_W = tag_w_of(CACHE_LINE, CACHE_SIZE);
  localparam int unsigned CNT_W = OFF_W + 1;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [OFF_W-1:0]      r_off;
  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_index;
  logic [CACHE_LINE-1:0] r_line;
  logic                  r_crit_valid;
  logic [31:0]           r_crit_data;
  logic                  r_line_valid;
  logic                  r_line_err;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_index;
  logic [OFF_W-1:0]      w_offset;
  logic [OFF_W-1:0]      w_word;
  logic                  w_last;

  addr_parser #(
    .CACHE_LINE(CACHE_LINE),
    .CACHE_SIZE(CACHE_SIZE)
  ) u_addr_parser (
    .i_addr  (bus.req_addr),
    .o_tag   (w_tag),
    .o_index (w_index),
    .o_offset(w_offset)
  );

  // Truncation to OFF_W bits gives the mod-BEATS wrap for free.
  assign w_word = r_off + r_cnt[OFF_W-1:0];
  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_off        <= '0;
      r_tag        <= '0;
      r_index      <= '0;
      r_line       <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      r_line_valid <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_crit_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_state    <= FILL;
            r_tag      <= w_tag;
            r_index    <= w_index;
            r_off      <= w_offset;
            r_cnt      <= '0;
            r_line_err <= 1'b0;
          end
        end
        FILL: begin
          if (bus.beat_valid) begin
            for (int unsigned w = 0; w < BEATS; w++) begin
              if (w_word == OFF_W'(w)) r_line[32*w +: 32] <= bus.beat_data;
            end
            r_cnt <= r_cnt + 1'b1;
            if (bus.beat_err) begin
              r_state      <= DONE;
              r_line_valid <= 1'b1;
              r_line_err   <= 1'b1;
            end else begin
              if (r_cnt == '0) begin
                r_crit_valid <= 1'b1;
                r_crit_data  <= bus.beat_data;
              end
              if (w_last) begin
                r_state      <= DONE;
                r_line_valid <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (bus.line_ready) begin
            r_state      <= IDLE;
            r_line_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.crit_valid = r_crit_valid;
  assign bus.crit_data  = r_crit_data;
  assign bus.line_valid = r_line_valid;
  assign bus.line_data  = r_line;
  assign bus.line_tag   = r_tag;
  assign bus.line_index = r_index;
  assign bus.line_err   = r_line_err;

endmodule

// File: tb/tb_line_refill_buffer.sv
// Directed plus randomized refills on a 128-bit (default) and a 256-bit instance.
module tb_line_refill_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        sel = 1'b0;
  logic        d_rv = 1'b0, d_bv = 1'b0, d_be = 1'b0, d_lr = 1'b0;
  logic [31:0] d_addr = '0, d_bd = '0;

  line_refill_buffer_if ifa ();
  line_refill_buffer_if #(.CACHE_LINE(256), .CACHE_SIZE(8192)) ifb ();

  line_refill_buffer dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  line_refill_buffer #(.CACHE_LINE(256), .CACHE_SIZE(8192)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  assign ifa.req_valid  = !sel && d_rv;
  assign ifb.req_valid  =  sel && d_rv;
  assign ifa.beat_valid = !sel && d_bv;
  assign ifb.beat_valid =  sel && d_bv;
  assign ifa.line_ready = !sel && d_lr;
  assign ifb.line_ready =  sel && d_lr;
  assign ifa.req_addr   = d_addr;
  assign ifb.req_addr   = d_addr;
  assign ifa.beat_data  = d_bd;
  assign ifb.beat_data  = d_bd;
  assign ifa.beat_err   = d_be;
  assign ifb.beat_err   = d_be;

  logic         o_rr, o_busy, o_cv, o_lv, o_le;
  logic [31:0]  o_cd, o_tag, o_idx;
  logic [255:0] o_ld;
  assign o_rr   = sel ? ifb.req_ready  : ifa.req_ready;
  assign o_busy = sel ? ifb.busy       : ifa.busy;
  assign o_cv   = sel ? ifb.crit_valid : ifa.crit_valid;
  assign o_lv   = sel ? ifb.line_valid : ifa.line_valid;
  assign o_le   = sel ? ifb.line_err   : ifa.line_err;
  assign o_cd   = sel ? ifb.crit_data  : ifa.crit_data;
  assign o_tag  = sel ? 32'(ifb.line_tag)   : 32'(ifa.line_tag);
  assign o_idx  = sel ? 32'(ifb.line_index) : 32'(ifa.line_index);
  assign o_ld   = sel ? ifb.line_data  : 256'(ifa.line_data);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input bit s);
    sel = s;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, o_rr, 1);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_cv"}, o_cv, 0);
    chk({tag, "_lv"}, o_lv, 0);
    chk({tag, "_le"}, o_le, 0);
    chk({tag, "_ld"}, o_ld, 0);
    chk({tag, "_cd"}, o_cd, 0);
    chk({tag, "_tag"}, o_tag, 0);
    chk({tag, "_idx"}, o_idx, 0);
  endtask

  // Reference: beat k lands in word (offset+k) mod BEATS; fields by plain division.
  task automatic refill(input bit s, input logic [31:0] addr, input logic [31:0] beats[8],
                        input int gap, input int err_beat, input int hold);
    int unsigned nb, nsets, off, idx_e, tag_e, w;
    int last;
    logic [255:0] exp_line, mask;
    nb    = s ? 8 : 4;
    nsets = 8192 * 8 / (nb * 32);
    off   = addr % nb;
    idx_e = (addr / nb) % nsets;
    tag_e = addr / (nb * nsets);
    last  = (err_beat >= 0) ? err_beat : int'(nb) - 1;
    exp_line = '0;
    mask     = '0;
    for (int k = 0; k < int'(nb); k++) begin
      w = (off + k) % nb;
      if (err_beat < 0 || k < err_beat) begin
        exp_line[32*w +: 32] = beats[k];
        mask[32*w +: 32]     = '1;
      end
    end

    select(s);
    chk("idle_ready", o_rr, 1);
    d_rv = 1'b1; d_addr = addr;
    tick();
    d_rv = 1'b0; d_addr = $urandom;
    chk("fill_busy", o_busy, 1);
    chk("fill_not_ready", o_rr, 0);

    for (int k = 0; k <= last; k++) begin
      repeat (gap) begin
        d_bv = 1'b0; d_bd = $urandom;
        tick();
        chk("gap_lv", o_lv, 0);
        chk("gap_cv", o_cv, 0);
      end
      d_bv = 1'b1; d_bd = beats[k]; d_be = (k == err_beat);
      tick();
      d_bv = 1'b0; d_be = 1'b0;
      chk("crit_valid", o_cv, (k == 0 && err_beat != 0));
      if (k == 0 && err_beat != 0) chk("crit_data", o_cd, beats[0]);
      chk("line_valid_edge", o_lv, (k == last));
    end

    chk("line_err", o_le, (err_beat >= 0));
    chk("line_data", o_ld & mask, exp_line);
    chk("line_tag", o_tag, tag_e);
    chk("line_index", o_idx, idx_e);

    if (err_beat >= 0) begin
      repeat (2) begin
        d_bv = 1'b1; d_bd = $urandom;
        tick();
        chk("err_hold_lv", o_lv, 1);
        chk("err_hold_busy", o_busy, 1);
        chk("err_hold_data", o_ld & mask, exp_line);
      end
      d_bv = 1'b0;
    end

    for (int h = 0; h < hold; h++) begin
      d_lr = 1'b0; d_rv = 1'b1; d_addr = $urandom;
      tick();
      chk("hold_lv", o_lv, 1);
      chk("hold_data", o_ld & mask, exp_line);
      chk("hold_tag", o_tag, tag_e);
      chk("hold_idx", o_idx, idx_e);
      chk("hold_err", o_le, (err_beat >= 0));
      chk("hold_not_ready", o_rr, 0);
    end
    d_rv = 1'b0;
    d_lr = 1'b1;
    tick();
    d_lr = 1'b0;
    chk("release_lv", o_lv, 0);
    chk("release_ready", o_rr, 1);
    chk("release_busy", o_busy, 0);
  endtask

  logic [31:0] bt[8];

  initial begin
    // Reset state on both instances.
    rst = 1'b1;
    tick(); tick();
    select(0); chk_reset_vals("rst_a");
    select(1); chk_reset_vals("rst_b");
    rst = 1'b0;
    tick();

    // Stray beat in IDLE is ignored.
    select(0);
    d_bv = 1'b1; d_bd = 32'hDEAD_BEEF;
    tick();
    d_bv = 1'b0;
    chk("idle_beat_ready", o_rr, 1);
    chk("idle_beat_busy", o_busy, 0);
    chk("idle_beat_cv", o_cv, 0);

    // Offset 2, back-to-back, line_ready high on first DONE cycle.
    bt = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    refill(0, 32'h0000_0A02, bt, 0, -1, 0);
    chk("fixed_line", o_ld, 256'h00000022_00000011_00000044_00000033);
    chk("fixed_tag", o_tag, 1);
    chk("fixed_idx", o_idx, 32'h080);

    // Offset 0 with 3-cycle gaps.
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    refill(0, $urandom & 32'hFFFF_FFFC, bt, 3, -1, 0);

    // Error on beat 2, then error on beat 0.
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    refill(0, $urandom, bt, 0, 2, 1);
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    refill(0, $urandom, bt, 1, 0, 0);

    // line_ready held low for 5 cycles.
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    refill(0, $urandom, bt, 0, -1, 5);

    // Reset after beat 1 aborts the refill.
    select(0);
    d_rv = 1'b1; d_addr = 32'h1234_5679;
    tick();
    d_rv = 1'b0;
    d_bv = 1'b1; d_bd = 32'hA5A5_0001;
    tick();
    d_bd = 32'hA5A5_0002;
    tick();
    d_bv = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_vals("midfill_rst");
    rst = 1'b0;
    tick();
    chk("post_rst_lv", o_lv, 0);
    chk("post_rst_ready", o_rr, 1);
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    refill(0, $urandom, bt, 0, -1, 0);

    // 256-bit instance, offset 7.
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    refill(1, ($urandom & 32'hFFFF_FFF8) | 32'h7, bt, 0, -1, 0);
    chk("b_word7", o_ld[255:224], bt[0]);
    chk("b_word0", o_ld[31:0], bt[1]);
    chk("b_word6", o_ld[223:192], bt[7]);

    // Randomized mix across both instances.
    for (int it = 0; it < 24; it++) begin
      bit s;
      int eb;
      s  = 1'($urandom_range(0, 1));
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, s ? 7 : 3)) : -1;
      for (int i = 0; i < 8; i++) bt[i] = $urandom;
      refill(s, $urandom, bt, int'($urandom_range(0, 2)), eb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
